ccta_sched: RTL and testbench

- Sequences the shared CCTA datapath (4-bit A/B/C operands, 1-bit ctrl mode, 5-bit result q) between NREQ requesters.
- Each requester offers an operand set over a valid/ready handshake.
- A round-robin arbiter grants one requester at a time. The block drives the CCTA operand and ctrl inputs, waits SETTLE_CYC cycles, captures q, and returns it tagged with the requester ID over a valid/ready response port.
- The block sits between requesting control logic and one CCTA instance.

---
 rtl/ccta_sched_pkg.sv | 14 +
 rtl/ccta_sched_rr_arbiter.sv | 30 +++
 rtl/ccta_sched.sv | 167 ++++++++++++++++
 tb/tb_ccta_sched.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/ccta_sched_pkg.sv
// Shared types and widths for the CCTA datapath scheduler.
package ccta_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } state_e;

    localparam int OPW = 4;
    localparam int QW  = 5;

endpackage

// File: rtl/ccta_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first valid requester at or above the
// pointer, wrapping modulo NREQ.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] valid_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] grant_oh_o,
    output logic [IDW-1:0]  grant_idx_o,
    output logic            any_grant_o
);

    always_comb begin
        grant_oh_o  = '0;
        grant_idx_o = '0;
        any_grant_o = 1'b0;
        // k is the scan distance from the pointer; j is the matching requester
        for (int k = 0; k < NREQ; k++) begin
            for (int j = 0; j < NREQ; j++) begin
                if (!any_grant_o && valid_i[j] && (j == (int'(ptr_i) + k) % NREQ)) begin
                    grant_oh_o[j] = 1'b1;
                    grant_idx_o   = IDW'(j);
                    any_grant_o   = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ccta_sched.sv
// Schedules one shared CCTA instance between NREQ requesters: arbitrate,
// hold operands for SETTLE_CYC cycles, capture q and return it tagged with the ID.
module ccta_sched
    import ccta_sched_pkg::*;
#(
    parameter int NREQ       = 2,
    parameter int SETTLE_CYC = 1,
    parameter int IDW        = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [OPW*NREQ-1:0] req_a,
    input  logic [OPW*NREQ-1:0] req_b,
    input  logic [OPW*NREQ-1:0] req_c,
    input  logic [NREQ-1:0]   req_ctrl,
    output logic [OPW-1:0]    ccta_a,
    output logic [OPW-1:0]    ccta_b,
    output logic [OPW-1:0]    ccta_c,
    output logic              ccta_ctrl,
    output logic              ccta_rst,
    input  logic [QW-1:0]     ccta_q,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [QW-1:0]     rsp_q,
    output logic [IDW-1:0]    rsp_id,
    output logic              busy
);

    localparam logic [2:0] CNT_LD = 3'(SETTLE_CYC - 1);

    state_e           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [OPW-1:0]   a_q, a_d, b_q, b_d, c_q, c_d;
    logic             ctrl_q, ctrl_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [QW-1:0]    rsp_q_q, rsp_q_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;
    logic             ccta_rst_q;

    logic [NREQ-1:0]  grant_oh;
    logic [IDW-1:0]   grant_idx;
    logic             any_grant;
    logic [OPW-1:0]   a_sel, b_sel, c_sel;
    logic             ctrl_sel;
    logic             arb_en;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .valid_i     (req_valid),
        .ptr_i       (ptr_q),
        .grant_oh_o  (grant_oh),
        .grant_idx_o (grant_idx),
        .any_grant_o (any_grant)
    );

    assign arb_en    = (state_q == ST_IDLE) && !ccta_rst_q;
    assign req_ready = arb_en ? grant_oh : '0;

    always_comb begin
        a_sel    = '0;
        b_sel    = '0;
        c_sel    = '0;
        ctrl_sel = 1'b0;
        for (int j = 0; j < NREQ; j++) begin
            if (grant_oh[j]) begin
                a_sel    = req_a[j*OPW +: OPW];
                b_sel    = req_b[j*OPW +: OPW];
                c_sel    = req_c[j*OPW +: OPW];
                ctrl_sel = req_ctrl[j];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        id_d        = id_q;
        a_d         = a_q;
        b_d         = b_q;
        c_d         = c_q;
        ctrl_d      = ctrl_q;
        rsp_valid_d = rsp_valid_q;
        rsp_q_d     = rsp_q_q;
        rsp_id_d    = rsp_id_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_en && any_grant) begin
                    a_d     = a_sel;
                    b_d     = b_sel;
                    c_d     = c_sel;
                    ctrl_d  = ctrl_sel;
                    id_d    = grant_idx;
                    ptr_d   = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
                    cnt_d   = CNT_LD;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (cnt_q == 3'd0) state_d = ST_CAPTURE;
                else               cnt_d   = cnt_q - 3'd1;
            end
            ST_CAPTURE: begin
                rsp_q_d     = ccta_q;
                rsp_valid_d = 1'b1;
                rsp_id_d    = id_q;
                // Operands are don't-care to the CCTA from here; zero them for determinism
                a_d         = '0;
                b_d         = '0;
                c_d         = '0;
                ctrl_d      = 1'b0;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            cnt_q       <= '0;
            id_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            ctrl_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_q_q     <= '0;
            rsp_id_q    <= '0;
            ccta_rst_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            id_q        <= id_d;
            a_q         <= a_d;
            b_q         <= b_d;
            c_q         <= c_d;
            ctrl_q      <= ctrl_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_q_q     <= rsp_q_d;
            rsp_id_q    <= rsp_id_d;
            ccta_rst_q  <= 1'b0;
        end
    end

    assign ccta_a    = a_q;
    assign ccta_b    = b_q;
    assign ccta_c    = c_q;
    assign ccta_ctrl = ctrl_q;
    assign ccta_rst  = ccta_rst_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_q     = rsp_q_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ccta_sched.sv
// Directed bench for ccta_sched: one instance with SETTLE_CYC=1, one with 3,
// each driving a stub CCTA (q = A+B, or A+C when ctrl=1).
module tb_ccta_sched;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [1:0] req_valid, req_ready, req_ctrl;
    logic [7:0] req_a, req_b, req_c;
    logic [3:0] ccta_a, ccta_b, ccta_c;
    logic       ccta_ctrl, ccta_rst, rsp_valid, rsp_ready, busy;
    logic [4:0] ccta_q, rsp_q;
    logic [1:0] rsp_id;

    logic [1:0] req3_valid, req3_ready, req3_ctrl;
    logic [7:0] req3_a, req3_b, req3_c;
    logic [3:0] ccta3_a, ccta3_b, ccta3_c;
    logic       ccta3_ctrl, ccta3_rst, rsp3_valid, rsp3_ready, busy3;
    logic [4:0] ccta3_q, rsp3_q;
    logic [1:0] rsp3_id;

    assign ccta_q  = ccta_ctrl  ? ({1'b0, ccta_a}  + {1'b0, ccta_c})  : ({1'b0, ccta_a}  + {1'b0, ccta_b});
    assign ccta3_q = ccta3_ctrl ? ({1'b0, ccta3_a} + {1'b0, ccta3_c}) : ({1'b0, ccta3_a} + {1'b0, ccta3_b});

    ccta_sched #(.NREQ(2), .SETTLE_CYC(1), .IDW(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_ctrl(req_ctrl),
        .ccta_a(ccta_a), .ccta_b(ccta_b), .ccta_c(ccta_c), .ccta_ctrl(ccta_ctrl),
        .ccta_rst(ccta_rst), .ccta_q(ccta_q),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_q(rsp_q), .rsp_id(rsp_id),
        .busy(busy)
    );

    ccta_sched #(.NREQ(2), .SETTLE_CYC(3), .IDW(2)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req3_valid), .req_ready(req3_ready),
        .req_a(req3_a), .req_b(req3_b), .req_c(req3_c), .req_ctrl(req3_ctrl),
        .ccta_a(ccta3_a), .ccta_b(ccta3_b), .ccta_c(ccta3_c), .ccta_ctrl(ccta3_ctrl),
        .ccta_rst(ccta3_rst), .ccta_q(ccta3_q),
        .rsp_valid(rsp3_valid), .rsp_ready(rsp3_ready), .rsp_q(rsp3_q), .rsp_id(rsp3_id),
        .busy(busy3)
    );

    int total = 0;
    int bad = 0;
    int n;
    logic [1:0] g;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Counts edges after the accepting edge until rsp_valid is seen (bounded)
    task automatic wait_rsp(output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (!rsp_valid && cnt < 20);
        $display("rsp id=%0d q=%0d after %0d cycles", rsp_id, rsp_q, cnt);
    endtask

    task automatic wait_grant(output logic [1:0] gnt);
        int k;
        k = 0;
        while (req_ready == 2'b00 && k < 20) begin
            tick();
            k++;
        end
        gnt = req_ready;
        $display("grant vector=%b", gnt);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) begin
            tick();
            chk("rst_ccta_rst", ccta_rst, 1);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_req_ready", req_ready, 0);
        end
        rst_n = 1'b1;
        #1;
        chk("rel_ccta_rst_hold", ccta_rst, 1);
        tick();
        chk("rel_ccta_rst_drop", ccta_rst, 0);
    endtask

    initial begin
        req_valid = '0; req_a = '0; req_b = '0; req_c = '0; req_ctrl = '0; rsp_ready = 1'b0;
        req3_valid = '0; req3_a = '0; req3_b = '0; req3_c = '0; req3_ctrl = '0; rsp3_ready = 1'b0;

        do_reset();
        chk("rst_busy", busy, 0);

        // Single request: 9 + 7 = 16 from requester 0
        req_valid = 2'b01; req_a[3:0] = 4'd9; req_b[3:0] = 4'd7; req_ctrl = 2'b00;
        #1;
        chk("single_ready", req_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        chk("single_busy", busy, 1);
        chk("single_ccta_a", ccta_a, 9);
        chk("single_ccta_b", ccta_b, 7);
        wait_rsp(n);
        chk("single_lat", n, 2);
        chk("single_q", rsp_q, 16);
        chk("single_id", rsp_id, 0);
        chk("single_ccta_zero", ccta_a, 0);
        rsp_ready = 1'b1;
        tick();
        chk("single_done_valid", rsp_valid, 0);
        chk("single_done_busy", busy, 0);

        // Round robin: req0 = 3+4 = 7, req1 = 15+15 = 30 (ctrl=1)
        do_reset();
        rsp_ready = 1'b1;
        req_valid = 2'b11;
        req_a = {4'd15, 4'd3}; req_b = {4'd0, 4'd4}; req_c = {4'd15, 4'd0}; req_ctrl = 2'b10;
        #1;
        for (int k = 0; k < 4; k++) begin
            wait_grant(g);
            chk("rr_grant", g, (k % 2 == 1) ? 2'b10 : 2'b01);
            tick();
            wait_rsp(n);
            chk("rr_lat", n, 2);
            chk("rr_id", rsp_id, k % 2);
            chk("rr_q", rsp_q, (k % 2 == 1) ? 30 : 7);
            chk("rr_no_grant_in_resp", req_ready, 0);
        end

        // Backpressure: requester 0 gets 2+3 = 5, held while rsp_ready=0
        req_a[3:0] = 4'd2; req_b[3:0] = 4'd3;
        tick();
        rsp_ready = 1'b0;
        wait_grant(g);
        chk("bp_grant", g, 2'b01);
        tick();
        wait_rsp(n);
        chk("bp_lat", n, 2);
        repeat (5) begin
            tick();
            chk("bp_valid", rsp_valid, 1);
            chk("bp_q", rsp_q, 5);
            chk("bp_id", rsp_id, 0);
            chk("bp_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        tick();
        chk("bp_released", rsp_valid, 0);
        chk("bp_next_grant", req_ready, 2'b10);
        req_valid = 2'b00;
        tick();

        // Reset mid-operation: 1+1 = 2 aborted in ISSUE, then regranted
        req_valid = 2'b01; req_a[3:0] = 4'd1; req_b[3:0] = 4'd1; req_ctrl = 2'b00;
        #1;
        chk("mr_ready", req_ready, 2'b01);
        tick();
        chk("mr_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mr_ccta_rst", ccta_rst, 1);
        chk("mr_rsp_valid", rsp_valid, 0);
        chk("mr_busy_cleared", busy, 0);
        chk("mr_ccta_a", ccta_a, 0);
        repeat (2) begin
            tick();
            chk("mr_hold_valid", rsp_valid, 0);
            chk("mr_hold_ready", req_ready, 0);
        end
        rst_n = 1'b1;
        tick();
        chk("mr_ccta_rst_drop", ccta_rst, 0);
        wait_grant(g);
        chk("mr_regrant", g, 2'b01);
        tick();
        wait_rsp(n);
        chk("mr_lat", n, 2);
        chk("mr_q", rsp_q, 2);
        chk("mr_id", rsp_id, 0);
        req_valid = 2'b00;
        tick();

        // SETTLE_CYC=3: 5+6 = 11, operands stable for 4 cycles
        req3_valid = 2'b01; req3_a[3:0] = 4'd5; req3_b[3:0] = 4'd6; req3_ctrl = 2'b00; rsp3_ready = 1'b1;
        #1;
        chk("s3_ready", req3_ready, 2'b01);
        tick();
        req3_valid = 2'b00;
        chk("s3_ccta_a", ccta3_a, 5);
        chk("s3_ccta_b", ccta3_b, 6);
        n = 0;
        do begin
            tick();
            n++;
            if (!rsp3_valid) begin
                chk("s3_ccta_a", ccta3_a, 5);
                chk("s3_ccta_b", ccta3_b, 6);
            end
        end while (!rsp3_valid && n < 20);
        $display("rsp3 id=%0d q=%0d after %0d cycles", rsp3_id, rsp3_q, n);
        chk("s3_lat", n, 4);
        chk("s3_q", rsp3_q, 11);
        chk("s3_id", rsp3_id, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
